instr_queue: RTL and testbench
==============================

# instr_queue

Dual-slot instruction queue between the fetch stage and the decode stage of the dual-issue pipeline. It accepts up to two fetched instructions per cycle with their PCs and 14-bit exception vectors, buffers them in order, and presents the two oldest entries to decode as the first and second instruction. The issue judge reports how many of the presented instructions were consumed (0, 1 or 2) each cycle. A flush empties the queue on redirect.

## Interface
- DEPTH, 16, number of entries; power of two, ≥4
- EXP_W, 14, exception vector width per instruction
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous queue clear (redirect/exception)
- in_valid  in  2  fetch slot valids; 2'b00 none, 2'b01 slot0 only, 2'b11 both; 2'b10 illegal
- in_instr0 / in_instr1  in  32  fetched instructions, slot0 older
- in_pc0 / in_pc1  in  32  their PCs
- in_exp0 / in_exp1  in  EXP_W  their fetch-time exception vectors
- in_ready  out  1  queue accepts a write this cycle
- out_valid  out  2  bit0 first slot valid, bit1 second slot valid
- out_instr_first / out_instr_second  out  32  head and head+1 instructions
- out_pc_first / out_pc_second  out  32  their PCs
- out_exp_first / out_exp_second  out  EXP_W  their exception vectors
- issue_cnt  in  2  instructions consumed by decode this cycle (0..2)
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer: head pointer, tail pointer and occupancy counter, all registered; pointers wrap modulo DEPTH.
- Write: when in_ready=1, store in_valid slots at tail and tail+1 in that order. wr_n = 0, 1 or 2. in_valid=2'b10 is treated as wr_n=0 and flagged by a simulation assertion.
- in_ready = (DEPTH − count ≥ 2). It is computed from the registered count only, and does not take same-cycle issue into account, so there is no combinational path from issue_cnt.
- Read: the outputs are combinational from the entries at head and head+1.
  - out_valid[0] = (count ≥ 1).
  - out_valid[1] = (count ≥ 2).
  - An invalid slot drives instr 32'h0 (NOP), pc 0 and exp 0.
- Issue: rd_n = min(issue_cnt, count), so over-issue is clamped; a simulation assertion fires when issue_cnt exceeds the available count. issue_cnt=2 with out_valid=2'b01 consumes one entry.
- Update rules:
  - head += rd_n
  - tail += wr_n
  - count_next = count + wr_n − rd_n, in $clog2(DEPTH)+1-bit arithmetic; it never exceeds DEPTH or goes below 0 by construction.
- flush: head, tail and count go to 0 next cycle. Flush takes priority over same-cycle write and issue; those are discarded.
- Entry storage is not cleared on flush or reset; only the pointers and count are.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - head, tail and count = 0.
  - Outputs: out_valid=2'b00, all out_* data = 0, in_ready=1, count=0.
- Latency: an entry written at edge N is visible on the outputs in the cycle after edge N. There is no bypass from in_* to out_*, including when the queue is empty.
- Order is preserved: out_instr_first is always the oldest unissued instruction.
- Simultaneous write and issue in one cycle: both apply.
- Full queue (count = DEPTH or DEPTH−1): in_ready=0 and writes are ignored even if issue frees space that cycle.
- Reset mid-operation clears the pointers immediately; outputs go to their reset values asynchronously.

## Structure
- Shared package: NOP_INSTR = 32'h0 and the EXP_W default. These are shared with the decode-stage exception field layout.
- One sub-module: instr_queue_mem.
  - DEPTH×(32+32+EXP_W) register array.
  - Two write ports, at tail and tail+1, with per-port enables.
  - Two asynchronous read ports, at head and head+1.
- Pointer, count, ready and valid logic lives in instr_queue.

## Test plan
- Reset then idle: out_valid=2'b00, out_instr_first=0, in_ready=1, count=0.
- Write 2'b11 with pc 0x100/0x104 and issue_cnt=0: next cycle out_valid=2'b11, out_pc_first=0x100, out_pc_second=0x104, count=2. Then issue_cnt=1: out_pc_first=0x104, out_valid=2'b01.
- Fill with pairs while issue_cnt=0 until count=DEPTH−1 (DEPTH=16: 7 pairs plus one single): in_ready=0, a further write is ignored, count stays 15. Then issue_cnt=2: count=13 next cycle and in_ready=1.
- Wrap-around: stream 40 sequential PCs in and issue 2 per cycle; the out_pc_first sequence equals the input order with no gaps or duplicates.
- With count=5, assert flush with in_valid=2'b11 and issue_cnt=2 in the same cycle: next cycle count=0 and out_valid=2'b00. A subsequent write of pc 0x200 appears as out_pc_first=0x200.
- With count=1 and issue_cnt=2: count becomes 0, the assertion fires, and the outputs show an empty queue.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared constants for the fetch/decode instruction queue.
// NOP_INSTR and the exception width are also used by the decode-stage exception field layout.
package instr_queue_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0;
  localparam int          EXP_W_DEFAULT = 14;

  // Number of fetch slots carried by an in_valid pattern.
  // The illegal pattern 2'b10 carries no instructions.
  function automatic logic [1:0] slotCount(input logic [1:0] valid);
    case (valid)
      2'b01:   slotCount = 2'd1;
      2'b11:   slotCount = 2'd2;
      default: slotCount = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_queue_mem.sv
// Entry storage for the instruction queue.
// It has two write ports and two asynchronous read ports. The entries have no reset.
module instr_queue_mem #(
  parameter int DEPTH = 16,
  parameter int EXP_W = 14,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we0,
  input  logic [PW-1:0]    i_waddr0,
  input  logic [31:0]      i_instr0,
  input  logic [31:0]      i_pc0,
  input  logic [EXP_W-1:0] i_exp0,
  input  logic             i_we1,
  input  logic [PW-1:0]    i_waddr1,
  input  logic [31:0]      i_instr1,
  input  logic [31:0]      i_pc1,
  input  logic [EXP_W-1:0] i_exp1,
  input  logic [PW-1:0]    i_raddr0,
  input  logic [PW-1:0]    i_raddr1,
  output logic [31:0]      o_instr0,
  output logic [31:0]      o_pc0,
  output logic [EXP_W-1:0] o_exp0,
  output logic [31:0]      o_instr1,
  output logic [31:0]      o_pc1,
  output logic [EXP_W-1:0] o_exp1
);

  logic [31:0]      r_instr [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic [EXP_W-1:0] r_exp   [DEPTH];

  // Two write ports. The top module always drives them with distinct addresses (tail and tail+1).
  always_ff @(posedge i_clk) begin
    if (i_we0) begin
      r_instr[i_waddr0] <= i_instr0;
      r_pc[i_waddr0]    <= i_pc0;
      r_exp[i_waddr0]   <= i_exp0;
    end
    if (i_we1) begin
      r_instr[i_waddr1] <= i_instr1;
      r_pc[i_waddr1]    <= i_pc1;
      r_exp[i_waddr1]   <= i_exp1;
    end
  end

  assign o_instr0 = r_instr[i_raddr0];
  assign o_pc0    = r_pc[i_raddr0];
  assign o_exp0   = r_exp[i_raddr0];
  assign o_instr1 = r_instr[i_raddr1];
  assign o_pc1    = r_pc[i_raddr1];
  assign o_exp1   = r_exp[i_raddr1];

endmodule

// File: rtl/instr_queue.sv
// Dual-slot in-order instruction queue between fetch and decode.
// It takes in up to two instructions per cycle and presents the two oldest entries to decode.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int EXP_W = EXP_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [31:0]              in_instr0,
  input  logic [31:0]              in_instr1,
  input  logic [31:0]              in_pc0,
  input  logic [31:0]              in_pc1,
  input  logic [EXP_W-1:0]         in_exp0,
  input  logic [EXP_W-1:0]         in_exp1,
  output logic                     in_ready,
  output logic [1:0]               out_valid,
  output logic [31:0]              out_instr_first,
  output logic [31:0]              out_instr_second,
  output logic [31:0]              out_pc_first,
  output logic [31:0]              out_pc_second,
  output logic [EXP_W-1:0]         out_exp_first,
  output logic [EXP_W-1:0]         out_exp_second,
  input  logic [1:0]               issue_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_ready;
  logic [1:0]       w_wrN;
  logic [1:0]       w_rdN;
  logic [1:0]       w_issueSat;
  logic [31:0]      w_instr0, w_instr1, w_pc0, w_pc1;
  logic [EXP_W-1:0] w_exp0, w_exp1;

  // Ready depends only on the registered occupancy, so issue_cnt has no path to in_ready.
  assign w_ready = (r_count <= CW'(DEPTH - 2));

  // Decide how many entries are written this cycle and how many are consumed.
  // Consumption is clamped to what is actually present in the queue.
  always_comb begin
    w_wrN      = 2'd0;
    w_rdN      = 2'd0;
    w_issueSat = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
    if (w_ready) w_wrN = slotCount(in_valid);
    if (r_count < CW'(w_issueSat)) w_rdN = r_count[1:0];
    else                            w_rdN = w_issueSat;
  end

  // Pointer and occupancy update. Flush wins over any same-cycle write or issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_rdN);
      r_tail  <= r_tail + PW'(w_wrN);
      r_count <= r_count + CW'(w_wrN) - CW'(w_rdN);
    end
  end

  instr_queue_mem #(.DEPTH(DEPTH), .EXP_W(EXP_W)) u_mem (
    .i_clk    (clk),
    .i_we0    (!flush && (w_wrN != 2'd0)),
    .i_waddr0 (r_tail),
    .i_instr0 (in_instr0),
    .i_pc0    (in_pc0),
    .i_exp0   (in_exp0),
    .i_we1    (!flush && (w_wrN == 2'd2)),
    .i_waddr1 (r_tail + PW'(1)),
    .i_instr1 (in_instr1),
    .i_pc1    (in_pc1),
    .i_exp1   (in_exp1),
    .i_raddr0 (r_head),
    .i_raddr1 (r_head + PW'(1)),
    .o_instr0 (w_instr0),
    .o_pc0    (w_pc0),
    .o_exp0   (w_exp0),
    .o_instr1 (w_instr1),
    .o_pc1    (w_pc1),
    .o_exp1   (w_exp1)
  );

  // Present the head entries to decode. An empty slot shows a NOP with a zero PC and zero exceptions.
  always_comb begin
    out_valid        = {(r_count >= CW'(2)), (r_count >= CW'(1))};
    out_instr_first  = out_valid[0] ? w_instr0 : NOP_INSTR;
    out_pc_first     = out_valid[0] ? w_pc0    : 32'h0;
    out_exp_first    = out_valid[0] ? w_exp0   : '0;
    out_instr_second = out_valid[1] ? w_instr1 : NOP_INSTR;
    out_pc_second    = out_valid[1] ? w_pc1    : 32'h0;
    out_exp_second   = out_valid[1] ? w_exp1   : '0;
  end

  assign in_ready = w_ready;
  assign count    = r_count;

  // Protocol warnings: the illegal fetch pattern and issuing more than is present.
  // Both cases are handled safely by the logic above.
  always @(posedge clk) begin
    if (!rst) begin
      assert (in_valid != 2'b10)
        else $warning("instr_queue: in_valid 2'b10 ignored");
      assert ({{(CW-2){1'b0}}, issue_cnt} <= r_count)
        else $warning("instr_queue: issue_cnt exceeds occupancy, clamped");
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Testbench for instr_queue: directed scenarios plus randomized traffic.
// Outputs are compared against a queue-based reference model.
module tb_instr_queue;

  localparam int DEPTH = 16;
  localparam int EXP_W = 14;

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [EXP_W-1:0] exp;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0]       in_valid;
  logic [31:0]      in_instr0, in_instr1, in_pc0, in_pc1;
  logic [EXP_W-1:0] in_exp0, in_exp1;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [31:0]      out_instr_first, out_instr_second, out_pc_first, out_pc_second;
  logic [EXP_W-1:0] out_exp_first, out_exp_second;
  logic [1:0]       issue_cnt;
  logic [4:0]       count;

  int   checks   = 0;
  int   failures = 0;
  ent_t mq[$];

  instr_queue #(.DEPTH(DEPTH), .EXP_W(EXP_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_instr0        (in_instr0),
    .in_instr1        (in_instr1),
    .in_pc0           (in_pc0),
    .in_pc1           (in_pc1),
    .in_exp0          (in_exp0),
    .in_exp1          (in_exp1),
    .in_ready         (in_ready),
    .out_valid        (out_valid),
    .out_instr_first  (out_instr_first),
    .out_instr_second (out_instr_second),
    .out_pc_first     (out_pc_first),
    .out_pc_second    (out_pc_second),
    .out_exp_first    (out_exp_first),
    .out_exp_second   (out_exp_second),
    .issue_cnt        (issue_cnt),
    .count            (count)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Compare every DUT output against the reference queue.
  task automatic checkOutput();
    int   sz;
    ent_t e0;
    ent_t e1;
    sz = mq.size();
    e0 = '0;
    e1 = '0;
    if (sz >= 1) e0 = mq[0];
    if (sz >= 2) e1 = mq[1];
    compare("count",       64'(count),            64'(sz));
    compare("in_ready",    64'(in_ready),         64'((DEPTH - sz) >= 2));
    compare("out_valid",   64'(out_valid),        64'({sz >= 2, sz >= 1}));
    compare("instr_first", 64'(out_instr_first),  64'(e0.instr));
    compare("pc_first",    64'(out_pc_first),     64'(e0.pc));
    compare("exp_first",   64'(out_exp_first),    64'(e0.exp));
    compare("instr_second",64'(out_instr_second), 64'(e1.instr));
    compare("pc_second",   64'(out_pc_second),    64'(e1.pc));
    compare("exp_second",  64'(out_exp_second),   64'(e1.exp));
  endtask

  // Drive one cycle of inputs, advance the model at the clock edge, then check at the falling edge.
  task automatic applyStimulus(input logic f, input logic [1:0] v, input logic [31:0] pcA,
                               input logic [1:0] iss);
    int   rd;
    ent_t e;
    flush     = f;
    in_valid  = v;
    in_pc0    = pcA;
    in_pc1    = pcA + 32'd4;
    in_instr0 = $urandom;
    in_instr1 = $urandom;
    in_exp0   = EXP_W'($urandom);
    in_exp1   = EXP_W'($urandom);
    issue_cnt = iss;
    @(posedge clk);
    if (f) begin
      mq.delete();
    end else begin
      logic ready;
      ready = (DEPTH - mq.size()) >= 2;
      rd = (int'(iss) > mq.size()) ? mq.size() : int'(iss);
      for (int k = 0; k < rd; k++) void'(mq.pop_front());
      if (ready && v[0]) begin
        e.instr = in_instr0; e.pc = in_pc0; e.exp = in_exp0;
        mq.push_back(e);
        if (v[1]) begin
          e.instr = in_instr1; e.pc = in_pc1; e.exp = in_exp1;
          mq.push_back(e);
        end
      end
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int       nextPc;
    int       n;
    logic [1:0] v;
    logic [1:0] iss;
    rst = 1'b1; flush = 1'b0; in_valid = 2'b00; issue_cnt = 2'd0;
    in_instr0 = '0; in_instr1 = '0; in_pc0 = '0; in_pc1 = '0; in_exp0 = '0; in_exp1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset then idle
    compare("rst_valid",    64'(out_valid),       64'h0);
    compare("rst_instr",    64'(out_instr_first), 64'h0);
    compare("rst_ready",    64'(in_ready),        64'h1);
    compare("rst_count",    64'(count),           64'h0);
    checkOutput();

    // Basic write then single issue
    applyStimulus(1'b0, 2'b11, 32'h100, 2'd0);
    compare("wr_valid",     64'(out_valid),     64'h3);
    compare("wr_pc_first",  64'(out_pc_first),  64'h100);
    compare("wr_pc_second", 64'(out_pc_second), 64'h104);
    compare("wr_count",     64'(count),         64'h2);
    applyStimulus(1'b0, 2'b00, 32'h0, 2'd1);
    compare("iss_pc_first", 64'(out_pc_first),  64'h104);
    compare("iss_valid",    64'(out_valid),     64'h1);

    // Fill to DEPTH-1 and confirm the extra write is dropped
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 2'b11, 32'h300 + 32'(8 * i), 2'd0);
    compare("full_count",   64'(count),    64'd15);
    compare("full_ready",   64'(in_ready), 64'h0);
    applyStimulus(1'b0, 2'b11, 32'h400, 2'd0);
    compare("full_drop",    64'(count),    64'd15);
    applyStimulus(1'b0, 2'b00, 32'h0, 2'd2);
    compare("drain_count",  64'(count),    64'd13);
    compare("drain_ready",  64'(in_ready), 64'h1);
    applyStimulus(1'b1, 2'b00, 32'h0, 2'd0);

    // Wrap-around stream of 40 PCs with two issued per cycle
    nextPc = 32'h1000;
    for (int i = 0; i < 22; i++) begin
      n = (mq.size() >= 2) ? 2 : mq.size();
      if (n > 0) compare("stream_pc", 64'(out_pc_first), 64'(nextPc));
      nextPc += 4 * n;
      v = (i < 20) ? 2'b11 : 2'b00;
      applyStimulus(1'b0, v, 32'h1000 + 32'(8 * i), 2'd2);
    end
    compare("stream_end", 64'(count), 64'h0);

    // Flush with a concurrent write and issue
    applyStimulus(1'b0, 2'b11, 32'h500, 2'd0);
    applyStimulus(1'b0, 2'b11, 32'h508, 2'd0);
    applyStimulus(1'b0, 2'b01, 32'h510, 2'd0);
    compare("pre_flush",    64'(count),     64'd5);
    applyStimulus(1'b1, 2'b11, 32'h600, 2'd2);
    compare("flush_count",  64'(count),     64'h0);
    compare("flush_valid",  64'(out_valid), 64'h0);
    applyStimulus(1'b0, 2'b01, 32'h200, 2'd0);
    compare("post_flush_pc",64'(out_pc_first), 64'h200);

    // Over-issue with a single entry
    applyStimulus(1'b0, 2'b00, 32'h0, 2'd2);
    compare("over_count",   64'(count),     64'h0);
    compare("over_valid",   64'(out_valid), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       v = 2'b00;
        1:       v = 2'b01;
        default: v = 2'b11;
      endcase
      iss = 2'($urandom_range(0, 2));
      if (int'(iss) > mq.size()) iss = 2'(mq.size());
      applyStimulus(($urandom_range(0, 40) == 0), v, $urandom & 32'hFFFF_FFFC, iss);
    end

    // Asynchronous reset in the middle of operation
    applyStimulus(1'b0, 2'b11, 32'h700, 2'd0);
    applyStimulus(1'b0, 2'b11, 32'h708, 2'd0);
    #2 rst = 1'b1;
    #1;
    compare("arst_count",   64'(count),           64'h0);
    compare("arst_valid",   64'(out_valid),       64'h0);
    compare("arst_instr",   64'(out_instr_first), 64'h0);
    compare("arst_ready",   64'(in_ready),        64'h1);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b01, 32'h800, 2'd0);
    compare("arst_resume",  64'(out_pc_first), 64'h800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
